writeback_queue: RTL and testbench

Buffers register writeback requests from the ALU and memory stages and drives the register file's single write port (`write_enable`, `write_addr`, `write_data`) one entry per cycle. It is the initiator side of the register-file write interface. It lets two results retire in the same cycle without losing either. It also publishes a per-register pending map so decode can detect writes still in flight.

---
 rtl/writeback_queue.sv | 164 ++++++++++++++++
 tb/tb_writeback_queue.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// writeback_queue
//   Collects register writeback requests from the memory and ALU stages and
//   drives the register file's single write port one entry per cycle.
//   Up to two requests can be accepted per cycle (memory first, then ALU).
//   A per-register pending map tells decode which writes are still in flight.
//
//   Optional feature: define WBQ_FORWARD_EN to build the forwarding lookup
//   (fwd_hit/fwd_data). Without it, both outputs are tied to zero and
//   fwd_addr is ignored.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    alu_valid,
  input  logic [ADDR_W-1:0]       alu_addr,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    stall,
  output logic                    write_enable,
  output logic [ADDR_W-1:0]       write_addr,
  output logic [DATA_W-1:0]       write_data,
  output logic [(1<<ADDR_W)-1:0]  pending,
  input  logic [ADDR_W-1:0]       fwd_addr,
  output logic                    fwd_hit,
  output logic [DATA_W-1:0]       fwd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;   // holds 0..DEPTH

  // ---------------------------------------------------------------------------
  // Queue state
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  // ---------------------------------------------------------------------------
  // Push / pop decisions (all derived from registered count, never from rst)
  // ---------------------------------------------------------------------------
  logic             push_mem;
  logic             push_alu;
  logic             pop;
  logic [PTR_W-1:0] alu_slot;
  logic [CNT_W-1:0] n_push;

  // Stall whenever fewer than two entries are free, so an accepted cycle can
  // always take both requests without checking them individually.
  assign stall    = (CNT_W'(DEPTH) - count) < CNT_W'(2);

  assign push_mem = mem_valid & ~stall;
  assign push_alu = alu_valid & ~stall;
  assign pop      = (count != '0);

  // Memory is the older instruction, so it takes the tail slot and ALU the
  // one after it; the ALU value is therefore written last for equal addresses.
  assign alu_slot = tail + PTR_W'(push_mem);
  assign n_push   = CNT_W'(push_mem) + CNT_W'(push_alu);

  // Entry storage: write accepted requests at the tail.
  // NOTE: the storage array has no reset; count/head decide which slots are
  // valid, so stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_mem) begin
        addr_mem[tail]     <= mem_addr;
        data_mem[tail]     <= mem_data;
      end
      if (push_alu) begin
        addr_mem[alu_slot] <= alu_addr;
        data_mem[alu_slot] <= alu_data;
      end
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(n_push);
      count <= count + n_push - CNT_W'(pop);
    end
  end

  // Output stage: present the popped head to the register file for one cycle;
  // address and data hold their last values while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else if (pop) begin
      write_enable <= 1'b1;
      write_addr   <= addr_mem[head];
      write_data   <= data_mem[head];
    end else begin
      write_enable <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending map: every valid queue slot plus the issuing output stage.
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] pend_idx;

  // Scan slots head..head+count-1 and flag their destination registers.
  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    pending  = '0;
    pend_idx = head;
    if (write_enable) pending[write_addr] = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      pend_idx = head + PTR_W'(k);
      if (CNT_W'(k) < count) pending[addr_mem[pend_idx]] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding lookup
  // ---------------------------------------------------------------------------
`ifdef WBQ_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Oldest-to-newest scan where each later match overrides an earlier one:
  // the output stage is oldest, then head up to tail-1, so the newest wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head;
    if (write_enable && (write_addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = write_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (addr_mem[fwd_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end
`else
  // Forwarding not built: constant outputs, lookup address ignored.
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^fwd_addr;
  assign fwd_hit         = 1'b0;
  assign fwd_data        = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed scenarios followed by randomized
// traffic, checked against a queue-based reference model and a write-order
// scoreboard. Works with or without WBQ_FORWARD_EN defined.
`timescale 1ns/1ps
module tb_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREG   = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_valid = 1'b0;
  logic [ADDR_W-1:0] mem_addr  = '0;
  logic [DATA_W-1:0] mem_data  = '0;
  logic              alu_valid = 1'b0;
  logic [ADDR_W-1:0] alu_addr  = '0;
  logic [DATA_W-1:0] alu_data  = '0;
  logic [ADDR_W-1:0] fwd_addr  = '0;
  logic              stall;
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [NREG-1:0]   pending;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .stall        (stall),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .pending      (pending),
    .fwd_addr     (fwd_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queued entries, the entry being written this cycle, and
  // the scoreboard of writes that must eventually appear, in order.
  // ---------------------------------------------------------------------------
  ent_t m_fifo[$];
  ent_t sb_q[$];
  ent_t m_out  = '0;
  ent_t m_last = '0;
  bit   m_out_valid = 1'b0;
  bit   accepted    = 1'b0;

  always @(posedge clk) begin
    bit full_ish;
    if (rst) begin
      m_fifo.delete();
      sb_q.delete();
      m_out_valid = 1'b0;
      m_last      = '0;
      accepted    = 1'b0;
    end else begin
      full_ish = (DEPTH - m_fifo.size()) < 2;
      if (m_fifo.size() > 0) begin
        m_out       = m_fifo.pop_front();
        m_out_valid = 1'b1;
        m_last      = m_out;
      end else begin
        m_out_valid = 1'b0;
      end
      accepted = !full_ish;
      if (!full_ish) begin
        if (mem_valid) begin
          m_fifo.push_back({mem_addr, mem_data});
          sb_q.push_back({mem_addr, mem_data});
        end
        if (alu_valid) begin
          m_fifo.push_back({alu_addr, alu_data});
          sb_q.push_back({alu_addr, alu_data});
        end
      end
    end
  end

  // Per-cycle comparison of status outputs, and the write monitor that pops
  // the scoreboard whenever the DUT issues a register-file write.
  always @(negedge clk) begin
    logic [NREG-1:0]   exp_pend;
    bit                exp_hit;
    logic [DATA_W-1:0] exp_fd;
    ent_t              want;

    exp_pend = '0;
    foreach (m_fifo[i]) exp_pend[m_fifo[i].addr] = 1'b1;
    if (m_out_valid) exp_pend[m_out.addr] = 1'b1;

    exp_hit = 1'b0;
    exp_fd  = '0;
`ifdef WBQ_FORWARD_EN
    for (int i = m_fifo.size() - 1; i >= 0; i--) begin
      if (!exp_hit && m_fifo[i].addr == fwd_addr) begin
        exp_hit = 1'b1;
        exp_fd  = m_fifo[i].data;
      end
    end
    if (!exp_hit && m_out_valid && m_out.addr == fwd_addr) begin
      exp_hit = 1'b1;
      exp_fd  = m_out.data;
    end
`endif

    check("stall",        stall,        ((DEPTH - m_fifo.size()) < 2) ? 1 : 0);
    check("write_enable", write_enable, m_out_valid);
    check("write_addr",   write_addr,   m_last.addr);
    check("write_data",   write_data,   m_last.data);
    check("pending",      pending,      exp_pend);
    check("fwd_hit",      fwd_hit,      exp_hit);
    check("fwd_data",     fwd_data,     exp_fd);

    if (write_enable === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_write", write_enable, 0);
      end else begin
        want = sb_q.pop_front();
        check("sb_addr", write_addr, want.addr);
        check("sb_data", write_data, want.data);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request pair and hold it until accepted, as a producer must.
  task automatic send(input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                      input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad);
    int n = 0;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    do begin
      step(1);
      n++;
    end while (!accepted && n < 50);
    check("send_accepted", accepted, 1);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then idle for five cycles.
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(5);

    // Single ALU write.
    send(0, 0, 0, 1, 3'd3, 16'h1234);
    step(4);

    // Dual push to the same register.
    send(1, 3'd5, 16'h00AA, 1, 3'd5, 16'h00BB);
    step(5);

    // Fill: back-to-back dual pushes, the third is held under stall.
    send(1, 3'd1, 16'hA001, 1, 3'd2, 16'hA002);
    send(1, 3'd3, 16'hA003, 1, 3'd4, 16'hA004);
    send(1, 3'd6, 16'hA005, 1, 3'd7, 16'hA006);
    step(8);

    // Pointer wrap: ten consecutive single pushes.
    for (int i = 0; i < 10; i++) send(0, 0, 0, 1, ADDR_W'(i % 8), 16'(16'h0100 + i));
    step(6);

    // Reset with three entries queued; requests during reset are dropped.
    send(1, 3'd1, 16'hB001, 1, 3'd2, 16'hB002);
    send(1, 3'd3, 16'hB003, 1, 3'd4, 16'hB004);
    rst = 1'b1;
    mem_valid = 1'b1; mem_addr = 3'd7; mem_data = 16'hDEAD;
    step(2);
    mem_valid = 1'b0;
    rst = 1'b0;
    step(4);

    // Forwarding lookups (expected hit only when the feature is built).
    fwd_addr = 3'd2;
    send(0, 0, 0, 1, 3'd2, 16'h0011);
    send(0, 0, 0, 1, 3'd2, 16'h0022);
    send(1, 3'd2, 16'h0033, 1, 3'd2, 16'h0044);
    fwd_addr = 3'd6;
    step(1);
    fwd_addr = 3'd2;
    step(5);

    // Randomized traffic with occasional resets; held requests stay put.
    for (int c = 0; c < 400; c++) begin
      if (accepted || !(mem_valid || alu_valid)) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_addr  = ADDR_W'($urandom);
        mem_data  = DATA_W'($urandom);
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_addr  = ADDR_W'($urandom);
        alu_data  = DATA_W'($urandom);
      end
      fwd_addr = ADDR_W'($urandom);
      rst      = ($urandom_range(0, 63) == 0);
      step(1);
    end
    rst       = 1'b0;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    step(20);
    check("drain_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
